phy_link_ctrl: RTL and testbench

- Link-bring-up controller that sequences the PHY transmit datapath; it owns the `active` signal consumed by the recirculator.
- Watches the byte stream recovered by the TX-side serial-to-paralelo converter (clk_4f domain) and walks the link through COM alignment and IDLE detection to ACTIVE.
- Drops `active` on loss of stream or alignment timeout; exposes link state for the probador.

---
 rtl/phy_link_pkg.sv | 14 +
 rtl/phy_link_ctrl_if.sv | 20 ++
 rtl/phy_link_cnt.sv | 24 ++
 rtl/phy_link_ctrl.sv | 119 +++++++++++
 tb/tb_phy_link_ctrl.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/phy_link_pkg.sv
// Shared encodings and symbol defaults for the PHY link-bring-up controller.
package phy_link_pkg;
    localparam int LS_W = 2;

    localparam logic [7:0] COM_SYM_D = 8'hBC;
    localparam logic [7:0] IDL_SYM_D = 8'h7C;

    typedef enum logic [LS_W-1:0] {
        ST_RESET     = 2'b00,
        ST_INIT      = 2'b01,
        ST_IDLE_WAIT = 2'b10,
        ST_ACTIVE    = 2'b11
    } link_state_t;
endpackage

// File: rtl/phy_link_ctrl_if.sv
// Byte-stream and link-status bundle between the serial-to-parallel side and the controller.
// err_cnt exists only when PHY_LINK_ERR_CNT_EN is defined.
interface phy_link_ctrl_if;
    import phy_link_pkg::*;

    logic [7:0]      byte_in;
    logic            byte_valid;
    logic            active;
    logic            idle_out;
    logic [LS_W-1:0] link_state;
`ifdef PHY_LINK_ERR_CNT_EN
    logic [7:0]      err_cnt;

    modport master (output byte_in, byte_valid, input active, idle_out, link_state, err_cnt);
    modport slave  (input byte_in, byte_valid, output active, idle_out, link_state, err_cnt);
`else
    modport master (output byte_in, byte_valid, input active, idle_out, link_state);
    modport slave  (input byte_in, byte_valid, output active, idle_out, link_state);
`endif
endinterface

// File: rtl/phy_link_cnt.sv
// Saturating up-counter with clear and enable; flags when the count equals TERM.
module phy_link_cnt #(
    parameter int           W    = 8,
    parameter logic [W-1:0] TERM = '1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_hit
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en && (r_cnt != '1))
            r_cnt <= r_cnt + W'(1);
    end

    assign o_hit = (r_cnt == TERM);
endmodule

// File: rtl/phy_link_ctrl.sv
// Link-bring-up FSM: COM alignment -> IDLE detection -> ACTIVE, with loss/timeout fallback.
// Optional error counter enabled by PHY_LINK_ERR_CNT_EN.
module phy_link_ctrl
    import phy_link_pkg::*;
#(
    parameter logic [7:0] COM_SYM  = COM_SYM_D,
    parameter logic [7:0] IDL_SYM  = IDL_SYM_D,
    parameter int         COM_REQ  = 4,
    parameter int         TIMEOUT  = 64,
    parameter int         LOSS_MAX = 8
) (
    input  logic            clk_4f,
    input  logic            reset,
    phy_link_ctrl_if.slave  bus
);
    link_state_t r_state, w_nxt;
    logic        r_active, r_idle;
    logic        w_active, w_idle;
    logic        w_com, w_idl;
    logic        w_com_hit, w_tmo_hit, w_loss_hit, w_com_clr;

    assign w_com = bus.byte_valid && (bus.byte_in == COM_SYM);
    assign w_idl = bus.byte_valid && (bus.byte_in == IDL_SYM);

    // Counters are held clear while outside their owning state, so each starts at 0 on entry.
    assign w_com_clr = (r_state != ST_INIT) || (bus.byte_valid && !w_com) || (w_com && w_com_hit);

    phy_link_cnt #(.W(4), .TERM(4'(COM_REQ - 1))) u_com_cnt (
        .clk   (clk_4f),
        .rst_n (reset),
        .i_clr (w_com_clr),
        .i_en  (w_com),
        .o_hit (w_com_hit)
    );

    phy_link_cnt #(.W(8), .TERM(8'(TIMEOUT - 1))) u_tmo_cnt (
        .clk   (clk_4f),
        .rst_n (reset),
        .i_clr (r_state != ST_IDLE_WAIT),
        .i_en  (1'b1),
        .o_hit (w_tmo_hit)
    );

    phy_link_cnt #(.W(8), .TERM(8'(LOSS_MAX - 1))) u_loss_cnt (
        .clk   (clk_4f),
        .rst_n (reset),
        .i_clr ((r_state != ST_ACTIVE) || bus.byte_valid),
        .i_en  (!bus.byte_valid),
        .o_hit (w_loss_hit)
    );

    always_comb begin
        w_nxt    = r_state;
        w_active = 1'b0;
        w_idle   = 1'b0;
        case (r_state)
            ST_RESET: w_nxt = ST_INIT;
            ST_INIT: begin
                if (w_com && w_com_hit)
                    w_nxt = ST_IDLE_WAIT;
            end
            ST_IDLE_WAIT: begin
                // IDL takes priority over a coincident timeout.
                if (w_idl) begin
                    w_nxt    = ST_ACTIVE;
                    w_active = 1'b1;
                    w_idle   = 1'b1;
                end else if ((bus.byte_valid && !w_com) || w_tmo_hit) begin
                    w_nxt = ST_INIT;
                end
            end
            ST_ACTIVE: begin
                w_active = 1'b1;
                w_idle   = r_idle;
                if (bus.byte_valid) begin
                    w_idle = w_idl;
                end else if (w_loss_hit) begin
                    w_nxt    = ST_INIT;
                    w_active = 1'b0;
                    w_idle   = 1'b0;
                end
            end
            default: w_nxt = ST_RESET;
        endcase
    end

    always_ff @(posedge clk_4f) begin
        if (!reset) begin
            r_state  <= ST_RESET;
            r_active <= 1'b0;
            r_idle   <= 1'b0;
        end else begin
            r_state  <= w_nxt;
            r_active <= w_active;
            r_idle   <= w_idle;
        end
    end

    assign bus.active     = r_active;
    assign bus.idle_out   = r_idle;
    assign bus.link_state = r_state;

`ifdef PHY_LINK_ERR_CNT_EN
    logic       w_err_ev;
    logic [7:0] r_err_cnt;

    assign w_err_ev = (w_nxt == ST_INIT) &&
                      ((r_state == ST_IDLE_WAIT) || (r_state == ST_ACTIVE));

    always_ff @(posedge clk_4f) begin
        if (!reset)
            r_err_cnt <= 8'd0;
        else if (w_err_ev && (r_err_cnt != 8'hFF))
            r_err_cnt <= r_err_cnt + 8'd1;
    end

    assign bus.err_cnt = r_err_cnt;
`endif
endmodule

// File: tb/tb_phy_link_ctrl.sv
// Directed bring-up scenarios plus randomized byte streams, checked every cycle
// against a behavioural model of the link rules.
module tb_phy_link_ctrl;
    localparam logic [7:0] BC = 8'hBC;
    localparam logic [7:0] IC = 8'h7C;
    localparam int COM_REQ  = 4;
    localparam int TIMEOUT  = 64;
    localparam int LOSS_MAX = 8;

    logic clk_4f = 1'b0;
    logic reset  = 1'b0;
    int   n_chk  = 0;
    int   n_err  = 0;

    // model state: phase 0 reset, 1 init, 2 idle-wait, 3 active
    int m_ph, m_com, m_tmo, m_loss, m_err;
    bit m_act, m_idle;

    always #5 clk_4f = ~clk_4f;

    phy_link_ctrl_if bus ();

    phy_link_ctrl u_dut (
        .clk_4f (clk_4f),
        .reset  (reset),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_step(input bit rst_n, input bit v, input logic [7:0] b);
        bit tmo_exp;
        if (!rst_n) begin
            m_ph = 0; m_com = 0; m_tmo = 0; m_loss = 0; m_err = 0;
            m_act = 0; m_idle = 0;
            return;
        end
        case (m_ph)
            0: begin m_ph = 1; m_com = 0; end
            1: begin
                if (v && b == BC) begin
                    m_com++;
                    if (m_com == COM_REQ) begin m_ph = 2; m_com = 0; m_tmo = 0; end
                end else if (v) m_com = 0;
            end
            2: begin
                tmo_exp = (m_tmo == TIMEOUT - 1);
                m_tmo++;
                if (v && b == IC) begin
                    m_ph = 3; m_act = 1; m_idle = 1; m_loss = 0;
                end else if ((v && b != BC) || tmo_exp) begin
                    m_ph = 1; m_com = 0;
                    if (m_err < 255) m_err++;
                end
            end
            default: begin
                if (v) begin
                    m_idle = (b == IC);
                    m_loss = 0;
                end else begin
                    m_loss++;
                    if (m_loss == LOSS_MAX) begin
                        m_ph = 1; m_com = 0; m_act = 0; m_idle = 0;
                        if (m_err < 255) m_err++;
                    end
                end
            end
        endcase
    endtask

    task automatic cyc(input bit rst_n, input bit v, input logic [7:0] b);
        reset = rst_n;
        bus.byte_valid = v;
        bus.byte_in = b;
        @(posedge clk_4f);
        model_step(rst_n, v, b);
        #1;
        chk("active", 32'(bus.active), 32'(m_act));
        chk("idle_out", 32'(bus.idle_out), 32'(m_idle));
        chk("link_state", 32'(bus.link_state), 32'(m_ph));
`ifdef PHY_LINK_ERR_CNT_EN
        chk("err_cnt", 32'(bus.err_cnt), 32'(m_err));
`endif
    endtask

    task automatic bring_up();
        cyc(0, 0, 8'h00);
        cyc(1, 0, 8'h00);
        for (int i = 0; i < COM_REQ; i++) cyc(1, 1, BC);
        cyc(1, 1, IC);
    endtask

    task automatic loss_event();
        for (int i = 0; i < LOSS_MAX; i++) cyc(1, 0, 8'h00);
    endtask

    initial begin
        int vp;
        bus.byte_in = 8'h00;
        bus.byte_valid = 1'b0;

        // reset held with COM traffic
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, BC);
            chk("rst_active", 32'(bus.active), 0);
            chk("rst_ls", 32'(bus.link_state), 0);
        end
        cyc(1, 0, 8'h00);
        chk("rst_rel_ls", 32'(bus.link_state), 1);

        // bring-up
        for (int i = 0; i < 3; i++) cyc(1, 1, BC);
        chk("bu_3bc_ls", 32'(bus.link_state), 1);
        cyc(1, 1, BC);
        chk("bu_4bc_ls", 32'(bus.link_state), 2);
        cyc(1, 1, IC);
        chk("bu_act", 32'(bus.active), 1);
        chk("bu_idle", 32'(bus.idle_out), 1);
        chk("bu_ls", 32'(bus.link_state), 3);

        // broken alignment
        cyc(0, 0, 8'h00);
        cyc(1, 0, 8'h00);
        cyc(1, 1, BC); cyc(1, 1, BC); cyc(1, 1, 8'h55);
        cyc(1, 1, BC); cyc(1, 1, BC); cyc(1, 1, BC);
        chk("brk_6_ls", 32'(bus.link_state), 1);
        cyc(1, 1, BC);
        chk("brk_7_ls", 32'(bus.link_state), 2);

        // timeout without IDL
        cyc(0, 0, 8'h00);
        cyc(1, 0, 8'h00);
        for (int i = 0; i < COM_REQ; i++) cyc(1, 1, BC);
        for (int i = 0; i < TIMEOUT - 1; i++) cyc(1, 1, BC);
        chk("tmo_63_ls", 32'(bus.link_state), 2);
        cyc(1, 1, BC);
        chk("tmo_64_ls", 32'(bus.link_state), 1);

        // IDL on the timeout cycle wins
        cyc(0, 0, 8'h00);
        cyc(1, 0, 8'h00);
        for (int i = 0; i < COM_REQ; i++) cyc(1, 1, BC);
        for (int i = 0; i < TIMEOUT - 1; i++) cyc(1, 1, BC);
        cyc(1, 1, IC);
        chk("tmo_idl_ls", 32'(bus.link_state), 3);

        // loss after data byte
        cyc(1, 1, 8'h3A);
        chk("loss_data_idle", 32'(bus.idle_out), 0);
        for (int i = 0; i < LOSS_MAX - 1; i++) cyc(1, 0, 8'h00);
        chk("loss_7_act", 32'(bus.active), 1);
        cyc(1, 0, 8'h00);
        chk("loss_8_act", 32'(bus.active), 0);
        chk("loss_8_ls", 32'(bus.link_state), 1);

        // gap one short of loss, then a valid byte keeps the link up
        bring_up();
        for (int i = 0; i < LOSS_MAX - 1; i++) cyc(1, 0, 8'h00);
        cyc(1, 1, IC);
        chk("noloss_act", 32'(bus.active), 1);
        chk("noloss_idle", 32'(bus.idle_out), 1);

        // mid-ACTIVE reset
        cyc(0, 1, IC);
        chk("mid_rst_act", 32'(bus.active), 0);
        chk("mid_rst_idle", 32'(bus.idle_out), 0);
        chk("mid_rst_ls", 32'(bus.link_state), 0);

`ifdef PHY_LINK_ERR_CNT_EN
        bring_up();
        loss_event();
        for (int i = 0; i < COM_REQ; i++) cyc(1, 1, BC);
        cyc(1, 1, IC);
        loss_event();
        for (int i = 0; i < COM_REQ; i++) cyc(1, 1, BC);
        cyc(1, 1, IC);
        loss_event();
        chk("err_3", 32'(bus.err_cnt), 3);
        cyc(0, 0, 8'h00);
        chk("err_rst", 32'(bus.err_cnt), 0);
`endif

        // randomized traffic, valid density varies per chunk
        cyc(0, 0, 8'h00);
        vp = 90;
        for (int i = 0; i < 4000; i++) begin
            int r;
            logic [7:0] b;
            if (i % 32 == 0) begin
                r = int'($urandom_range(2));
                vp = (r == 0) ? 95 : (r == 1) ? 60 : 8;
            end
            r = int'($urandom_range(99));
            b = (r < 60) ? BC : (r < 80) ? IC : 8'($urandom);
            cyc(($urandom_range(299) != 0), (int'($urandom_range(99)) < vp), b);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
